// File: rtl/currency_collector_if.sv
// Bundle between the vend controller side and the currency collector.
// The "slave" modport is the collector; the "master" modport is whatever drives it.
interface currency_collector_if #(
  parameter int CREDIT_W = 8
);
  // Inputs to the collector.
  logic                cfg_mode;
  logic                selection_valid;
  logic [CREDIT_W-1:0] item_price;
  logic                coin_valid;
  logic [1:0]          coin_type;
  logic                cancel;
  logic                dispense_valid;
  logic                change_ready;
  // Outputs from the collector.
  logic                currency_avail;
  logic [CREDIT_W-1:0] credit;
  logic                coin_reject;
  logic                change_valid;
  logic [CREDIT_W-1:0] change_amount;
  logic [1:0]          state_dbg;

  // Change handshake: change_valid rises with change_amount already stable and both
  // hold unchanged until a cycle where change_ready is also high. That cycle is the
  // transfer. change_valid drops after it, and the amount is never withdrawn.
  modport master (
    output cfg_mode, selection_valid, item_price, coin_valid, coin_type,
           cancel, dispense_valid, change_ready,
    input  currency_avail, credit, coin_reject, change_valid, change_amount,
           state_dbg
  );

  modport slave (
    input  cfg_mode, selection_valid, item_price, coin_valid, coin_type,
           cancel, dispense_valid, change_ready,
    output currency_avail, credit, coin_reject, change_valid, change_amount,
           state_dbg
  );
endinterface

// File: rtl/currency_collector.sv
// Currency collector: latches price, accumulates coins, signals paid, returns change/refund.
// Optional macro ESCROW_TIMEOUT_EN adds an idle-collect timeout that refunds like cancel.
module currency_collector #(
  parameter int CREDIT_W       = 8,
  parameter int COIN0_VAL      = 5,
  parameter int COIN1_VAL      = 10,
  parameter int COIN2_VAL      = 20,
  parameter int COIN3_VAL      = 50,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 rstn,
  currency_collector_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PAID    = 2'd2,
    CHANGE  = 2'd3
  } state_t;

  state_t              state;
  logic [CREDIT_W-1:0] price_q;
  logic [CREDIT_W-1:0] credit_q;
  logic [CREDIT_W-1:0] change_q;
  logic                avail_q;
  logic                reject_q;
  logic                cvalid_q;

  logic [CREDIT_W:0]   coin_sum;
  logic                coin_fits;
  logic [CREDIT_W-1:0] collect_credit;
  logic                tmo_hit;
  logic                abort;
  logic                do_exit;
  logic [CREDIT_W-1:0] exit_amt;

  function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] t);
    case (t)
      2'd0:    return CREDIT_W'(COIN0_VAL);
      2'd1:    return CREDIT_W'(COIN1_VAL);
      2'd2:    return CREDIT_W'(COIN2_VAL);
      default: return CREDIT_W'(COIN3_VAL);
    endcase
  endfunction

  // One extra bit so a coin that would wrap the credit register is detected and rejected.
  assign coin_sum       = {1'b0, credit_q} + {1'b0, coin_value(bus.coin_type)};
  assign coin_fits      = ~coin_sum[CREDIT_W];
  assign collect_credit = (bus.coin_valid && coin_fits) ? coin_sum[CREDIT_W-1:0] : credit_q;
  assign abort          = bus.cancel | bus.cfg_mode | tmo_hit;

`ifdef ESCROW_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1) + 1;
  logic [TW-1:0] tmo_cnt;

  // The timeout only fires in a cycle without a coin.
  assign tmo_hit = (state == COLLECT) && !bus.coin_valid &&
                   (tmo_cnt >= TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmo_cnt <= '0;
    end else if (state != COLLECT) begin
      tmo_cnt <= '0;
    end else if (bus.coin_valid && coin_fits && !bus.cancel && !bus.cfg_mode) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt < TW'(TIMEOUT_CYCLES)) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Exits that close a transaction and may produce change.
  always_comb begin
    do_exit  = 1'b0;
    exit_amt = credit_q;
    case (state)
      COLLECT: do_exit = abort;
      PAID: begin
        if (bus.dispense_valid) begin
          do_exit  = 1'b1;
          exit_amt = credit_q - price_q;
        end else if (bus.cancel || bus.cfg_mode) begin
          do_exit  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      price_q  <= '0;
      credit_q <= '0;
      change_q <= '0;
      avail_q  <= 1'b0;
      reject_q <= 1'b0;
      cvalid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          credit_q <= '0;
          reject_q <= bus.coin_valid;
          if (bus.selection_valid && !bus.cfg_mode) begin
            price_q <= bus.item_price;
            state   <= COLLECT;
          end
        end
        COLLECT: begin
          if (do_exit) begin
            reject_q <= bus.coin_valid;
          end else begin
            reject_q <= bus.coin_valid && !coin_fits;
            credit_q <= collect_credit;
            if (collect_credit >= price_q) begin
              state   <= PAID;
              avail_q <= 1'b1;
            end
          end
        end
        PAID: begin
          reject_q <= bus.coin_valid;
        end
        CHANGE: begin
          reject_q <= bus.coin_valid;
          if (cvalid_q && bus.change_ready) begin
            cvalid_q <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Closing a transaction overrides the per-state updates above.
      if (do_exit) begin
        avail_q  <= 1'b0;
        credit_q <= '0;
        change_q <= exit_amt;
        if (exit_amt == '0) begin
          state <= IDLE;
        end else begin
          state    <= CHANGE;
          cvalid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.currency_avail = avail_q;
  assign bus.credit         = credit_q;
  assign bus.coin_reject    = reject_q;
  assign bus.change_valid   = cvalid_q;
  assign bus.change_amount  = change_q;
  assign bus.state_dbg      = state;

endmodule
